// File: rtl/lfsr_checker.sv
// Self-check stage for a 4-bit x^4+x^3+1 PRBS stream.
// Seeds from the stream, locks after a run of good predictions, then free-runs and counts mismatches.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic [3:0]       i_in_data,
    input  logic             i_err_clr,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_zero_det
);

    // state  | meaning
    // SEED   | waiting for a nonzero sample to seed the predictor
    // HUNT   | predictor follows the data, counting consecutive good predictions
    // LOCKED | predictor free-runs; mismatches are flagged and counted

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [3:0]       r_expected;
    logic [3:0]       r_run;
    logic             r_locked;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_err_count;
    logic             r_zero_det;

    state_t           w_state_nx;
    logic [3:0]       w_expected_nx;
    logic [3:0]       w_run_nx;
    logic             w_locked_nx;
    logic             w_err_pulse_nx;
    logic [CNT_W-1:0] w_err_count_nx;
    logic             w_zero_det_nx;
    logic [3:0]       w_run_inc;
    logic             w_match;
    logic             w_data_zero;

    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    assign w_run_inc   = r_run + 4'd1;
    assign w_match     = (i_in_data == r_expected);
    assign w_data_zero = (i_in_data == 4'd0);

    always_comb begin
        w_state_nx     = r_state;
        w_expected_nx  = r_expected;
        w_run_nx       = r_run;
        w_locked_nx    = r_locked;
        w_err_pulse_nx = 1'b0;
        w_err_count_nx = r_err_count;
        w_zero_det_nx  = 1'b0;

        if (i_in_valid) begin
            // Zero is the lock-up value; it can never be a correct prediction.
            w_zero_det_nx = w_data_zero;
            case (r_state)
                SEED: begin
                    if (!w_data_zero) begin
                        w_expected_nx = lfsr_next(i_in_data);
                        w_run_nx      = 4'd0;
                        w_state_nx    = HUNT;
                    end
                end
                HUNT: begin
                    w_expected_nx = lfsr_next(i_in_data);
                    if (w_match) begin
                        w_run_nx = w_run_inc;
                        if (w_run_inc == LOCK_C) begin
                            w_state_nx  = LOCKED;
                            w_locked_nx = 1'b1;
                            w_run_nx    = 4'd0;
                        end
                    end else begin
                        w_run_nx = 4'd0;
                        if (w_data_zero) begin
                            w_state_nx = SEED;
                        end
                    end
                end
                LOCKED: begin
                    w_expected_nx = lfsr_next(r_expected);
                    if (w_match) begin
                        w_run_nx = 4'd0;
                    end else begin
                        w_err_pulse_nx = 1'b1;
                        if (r_err_count != {CNT_W{1'b1}}) begin
                            w_err_count_nx = r_err_count + CNT_ONE;
                        end
                        w_run_nx = w_run_inc;
                        if (w_run_inc == LOSS_C) begin
                            w_state_nx  = SEED;
                            w_locked_nx = 1'b0;
                            w_run_nx    = 4'd0;
                        end
                    end
                end
                default: begin
                    w_state_nx  = SEED;
                    w_locked_nx = 1'b0;
                    w_run_nx    = 4'd0;
                end
            endcase
        end

        if (i_err_clr) begin
            w_err_count_nx = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= SEED;
            r_expected  <= 4'd0;
            r_run       <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_zero_det  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_expected  <= w_expected_nx;
            r_run       <= w_run_nx;
            r_locked    <= w_locked_nx;
            r_err_pulse <= w_err_pulse_nx;
            r_err_count <= w_err_count_nx;
            r_zero_det  <= w_zero_det_nx;
        end
    end

    assign o_locked    = r_locked;
    assign o_err_pulse = r_err_pulse;
    assign o_err_count = r_err_count;
    assign o_zero_det  = r_zero_det;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios plus randomized stream against a table-driven model.
// A second instance with a 2-bit counter exercises saturation on the same stimulus.
module tb_lfsr_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       err_clr;

    logic       locked_a, pulse_a, zero_a;
    logic [7:0] cnt_a;
    logic       locked_b, pulse_b, zero_b;
    logic [1:0] cnt_b;

    lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
        .i_err_clr(err_clr), .o_locked(locked_a), .o_err_pulse(pulse_a),
        .o_err_count(cnt_a), .o_zero_det(zero_a)
    );

    lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(2)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
        .i_err_clr(err_clr), .o_locked(locked_b), .o_err_pulse(pulse_b),
        .o_err_count(cnt_b), .o_zero_det(zero_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // One full period of the sequence, starting at 0001.
    logic [3:0] seq [15];
    int g = 0;

    // Reference model: mode 0 = seeding, 1 = hunting, 2 = locked.
    int         m_mode;
    logic [3:0] m_exp;
    int         m_run;
    int         m_cnt8, m_cnt2;
    bit         m_pulse, m_zero;
    int         n_pulses_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] q);
        for (int i = 0; i < 15; i++)
            if (seq[i] == q) return seq[(i + 1) % 15];
        return 4'd0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_exp = 4'd0; m_run = 0;
        m_cnt8 = 0; m_cnt2 = 0; m_pulse = 0; m_zero = 0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] d, input bit clr);
        m_pulse = 0;
        m_zero  = 0;
        if (v) begin
            m_zero = (d == 4'd0);
            if (m_mode == 0) begin
                if (d != 4'd0) begin
                    m_exp = nxt(d); m_run = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (d == m_exp) begin
                    m_run++;
                    m_exp = nxt(d);
                    if (m_run == LOCK_CNT) begin m_mode = 2; m_run = 0; end
                end else begin
                    m_run = 0;
                    m_exp = nxt(d);
                    if (d == 4'd0) m_mode = 0;
                end
            end else begin
                bit bad;
                bad   = (d != m_exp);
                m_exp = nxt(m_exp);
                if (!bad) m_run = 0;
                else begin
                    m_pulse = 1;
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                    m_run++;
                    if (m_run == LOSS_CNT) begin m_mode = 0; m_run = 0; end
                end
            end
        end
        if (clr) begin m_cnt8 = 0; m_cnt2 = 0; end
    endtask

    task automatic check_all();
        chk("locked",      32'(locked_a), 32'(m_mode == 2));
        chk("err_pulse",   32'(pulse_a),  32'(m_pulse));
        chk("zero_det",    32'(zero_a),   32'(m_zero));
        chk("err_count",   32'(cnt_a),    32'(m_cnt8));
        chk("locked_s",    32'(locked_b), 32'(m_mode == 2));
        chk("err_pulse_s", 32'(pulse_b),  32'(m_pulse));
        chk("err_count_s", 32'(cnt_b),    32'(m_cnt2));
        if (pulse_b) n_pulses_b++;
    endtask

    task automatic step(input bit v, input logic [3:0] d, input bit clr);
        @(negedge clk);
        in_valid = v; in_data = d; err_clr = clr;
        @(posedge clk);
        #1;
        model_step(v, d, clr);
        check_all();
    endtask

    task automatic good(input bit clr = 0);
        step(1'b1, seq[g], clr);
        g = (g + 1) % 15;
    endtask

    task automatic bad(input bit clr = 0);
        logic [3:0] d;
        d = seq[g] ^ 4'b1010;
        step(1'b1, d, clr);
        g = (g + 1) % 15;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; err_clr = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        g = 0;
    endtask

    initial begin
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; err_clr = 1'b0;
        n_pulses_b = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        do_reset();

        // Lock-in after 1+LOCK_CNT samples
        repeat (4) good();
        chk("pre_lock", 32'(locked_a), 32'd0);
        good();
        chk("lockin", 32'(locked_a), 32'd1);

        // Single zero error, then resume (g now points at 0110)
        step(1'b1, 4'b0000, 1'b0); g++;
        chk("single_pulse", 32'(pulse_a), 32'd1);
        chk("single_zero",  32'(zero_a),  32'd1);
        chk("single_cnt",   32'(cnt_a),   32'd1);
        step(1'b1, 4'b1101, 1'b0); g++;
        chk("resume_nopulse", 32'(pulse_a), 32'd0);

        // Loss of lock
        step(1'b1, 4'b1111, 1'b1);
        chk("clr_with_err", 32'(cnt_a), 32'd0);
        step(1'b1, 4'b1111, 1'b0);
        chk("loss_held", 32'(locked_a), 32'd1);
        step(1'b1, 4'b1111, 1'b0);
        chk("loss_drop", 32'(locked_a), 32'd0);
        chk("loss_cnt",  32'(cnt_a),    32'd2);
        g = 0;
        repeat (5) good();
        chk("relock", 32'(locked_a), 32'd1);

        // Valid gaps through a full period
        for (int i = 0; i < 15; i++) begin
            good();
            step(1'b0, 4'd0, 1'b0);
        end
        chk("gap_locked", 32'(locked_a), 32'd1);

        // Saturation on the 2-bit instance, then clear alongside an error
        step(1'b0, 4'd0, 1'b1);
        n_pulses_b = 0;
        for (int i = 0; i < 5; i++) begin
            bad();
            good();
        end
        chk("sat_cnt",    32'(cnt_b),      32'd3);
        chk("sat_pulses", 32'(n_pulses_b), 32'd5);
        bad(1'b1);
        chk("sat_clr_cnt",   32'(cnt_b),   32'd0);
        chk("sat_clr_pulse", 32'(pulse_b), 32'd1);
        good();

        // Async reset mid-lock with err_count=2
        bad(); good(); bad(); good();
        chk("pre_rst_cnt", 32'(cnt_a), 32'(m_cnt8));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_locked", 32'(locked_a), 32'd0);
        chk("async_cnt",    32'(cnt_a),    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'd0, 1'b0);
        chk("seed_zero", 32'(zero_a), 32'd1);
        g = 0;
        repeat (4) good();
        chk("seed_hunt", 32'(locked_a), 32'd0);
        good();
        chk("seed_relock", 32'(locked_a), 32'd1);

        // Randomized stream: gaps, errors, zeros, jumps and clears
        for (int i = 0; i < 2000; i++) begin
            int r;
            bit clr;
            r   = int'($urandom_range(0, 99));
            clr = ($urandom_range(0, 49) == 0);
            if (r < 20) step(1'b0, 4'($urandom_range(0, 15)), clr);
            else if (r < 30) bad(clr);
            else if (r < 33) begin step(1'b1, 4'd0, clr); g = (g + 1) % 15; end
            else if (r < 35) begin g = int'($urandom_range(0, 14)); good(clr); end
            else good(clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Downstream consumer of the 4-bit LFSR pattern generator.
- Samples the generator's 4-bit output each valid cycle and predicts the next value with the same polynomial.
- Locks onto the stream, then flags and counts mismatches.
- Used as the self-check stage in PRBS loopback and BIST paths.

Parameters:
LOCK_CNT, 4, consecutive correct predictions in HUNT required to assert locked (1..15)
LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock (1..15)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous assert, active-low; state is reset while rst==0
in_valid  input  1  in_data is a valid LFSR sample this cycle
in_data  input  4  LFSR output sample
err_clr  input  1  synchronous clear of err_count
locked  output  1  checker is locked to the stream
err_pulse  output  1  one-cycle pulse on each LOCKED-state mismatch
err_count  output  CNT_W  saturating count of LOCKED-state mismatches
zero_det  output  1  one-cycle pulse when an all-zero sample is received (lock-up value)

Behaviour:
- Polynomial is x^4+x^3+1, Fibonacci, shift-left form: next(q) = {q[2:0], q[3]^q[2]}.
- Period is 15. From 0001: 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001.
- Internal state: FSM {SEED, HUNT, LOCKED}; expected[3:0]; run counter[3:0].
- Reset (rst==0): FSM=SEED, expected=0000, run=0, locked=0, err_pulse=0, err_count=0, zero_det=0.
- All outputs are registered. Each one reflects the sample consumed on the previous edge, i.e. 1-cycle latency.
- Cycles with in_valid=0: all state holds; err_pulse and zero_det deassert.
- SEED:
  - On a valid nonzero sample: expected<=next(in_data), run<=0, go to HUNT.
  - On a valid zero sample: zero_det pulses and the FSM stays in SEED.
- HUNT:
  - On a valid sample equal to expected: run<=run+1 and expected<=next(in_data). If run+1==LOCK_CNT, go to LOCKED and set locked=1.
  - On a valid mismatch: run<=0 and expected<=next(in_data), i.e. re-seed from the sample. If in_data==0, pulse zero_det and go to SEED.
  - In HUNT, a mismatch produces no err_pulse and no counter change.
- LOCKED:
  - Every valid cycle: expected<=next(expected). The checker free-runs and does not follow the data.
  - Match: run<=0.
  - Mismatch: err_pulse=1, err_count increments (saturating at all-ones), run<=run+1.
  - If run+1==LOSS_CNT: go to SEED, locked=0, run<=0. err_count is retained.
  - A zero sample in LOCKED counts as a normal mismatch and also pulses zero_det.
- err_clr: sets err_count=0 on the next edge. If err_clr and a mismatch occur in the same cycle, err_clr wins (count=0), but err_pulse still fires.
- Saturation: at 2^CNT_W-1 the count holds; err_pulse continues to fire.
- Reset mid-operation: immediate return to the reset values. No residual lock is kept.

Test Plan:
- Lock-in: release rst, feed valid 0001, 0010, 0100, 1001, 0011 on consecutive cycles -> locked=1 one cycle after the 0011 sample; err_count=0; err_pulse never asserted.
- Single error: while locked, substitute 0000 for expected 0110, then resume with 1101 -> err_pulse and zero_det both pulse once; err_count=1; locked stays 1; the 1101 sample matches.
- Loss of lock: while locked, feed 3 consecutive wrong values (e.g. 1111, 1111, 1111) -> err_count=3; locked=0 one cycle after the third sample; FSM in SEED; re-feeding the sequence relocks after 1+LOCK_CNT samples.
- Valid gaps: interleave in_valid=0 cycles (data=0000) through a full 15-sample period while locked -> no errors, no zero_det, locked held throughout.
- Clear/saturation: with CNT_W=2, inject 5 isolated errors (each followed by a good sample) -> count reaches 3 and holds; err_pulse fires 5 times. Then err_clr in the same cycle as a 6th error -> err_count=0 and err_pulse=1.
- Async reset mid-lock: drop rst between clock edges while locked with err_count=2 -> locked=0 and err_count=0 immediately, without waiting for a clock edge; after release, SEED waits for a nonzero sample.
